pic_host_sequencer: RTL

CPU-side bus sequencer for the 8259 PIC top module. After reset it drives the PIC's CS/WR/A1/data bus to program ICW1..ICW4 and OCW1. It then services the PIC: on interrupt_to_cpu it runs the two-pulse INTA sequence, captures the vector, and issues a non-specific EOI unless auto-EOI is configured. It also gives a host request port single OCW writes and status reads, so the PIC is not driven from ad-hoc stimulus.

---
 rtl/pic_host_sequencer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/pic_host_sequencer.sv
// pic_host_sequencer
//   CPU-side bus sequencer for an 8259-style PIC. After reset it programs
//   ICW1..ICW4 and OCW1, then services the PIC: on interrupt_to_cpu it runs
//   the two-pulse INTA sequence, captures the vector and issues a
//   non-specific EOI unless auto-EOI is configured. Between interrupts it
//   accepts single host read/write cycles on the cmd_* port.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   CS, wr_enable,       PIC chip select / write strobe / read strobe,
//   rd_enable            all active-low
//   A1                   PIC address bit
//   data_out, data_oe    byte toward the PIC and its drive enable
//   data_in              PIC bus read-back (vector / status)
//   int_ack              INTA toward the PIC, active-low
//   interrupt_to_cpu     PIC INT, active-high
//   cmd_valid/ready      host request handshake
//   cmd_read, cmd_a1,    host cycle type, address bit and write byte
//   cmd_data
//   rsp_valid, rsp_data  one-cycle read response
//   vector, vector_valid last captured vector and its update pulse
//   init_done            sticky initialization-complete flag
//   busy                 sequencer is not in IDLE
module pic_host_sequencer #(
    parameter logic [7:0] ICW1_VAL      = 8'h13,
    parameter logic [7:0] ICW2_VAL      = 8'h10,
    parameter logic [7:0] ICW3_VAL      = 8'h00,
    parameter logic [7:0] ICW4_VAL      = 8'h05,
    parameter logic [7:0] OCW1_VAL      = 8'h00,
    parameter logic [7:0] EOI_CMD       = 8'h20,
    parameter int         STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       CS,
    output logic       wr_enable,
    output logic       rd_enable,
    output logic       A1,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    output logic       int_ack,
    input  logic       interrupt_to_cpu,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_read,
    input  logic       cmd_a1,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       init_done,
    output logic       busy
);

    typedef enum logic [3:0] {
        INIT_WR, IDLE,
        WR_SETUP, WR_STROBE, WR_HOLD,
        RD_SETUP, RD_STROBE, RD_HOLD,
        ACK1, ACK_GAP, ACK2, ACK_DONE,
        EOI_WR
    } state_t;

    typedef enum logic [2:0] {
        STEP_ICW1, STEP_ICW2, STEP_ICW3, STEP_ICW4, STEP_OCW1
    } step_t;

    localparam bit SEND_ICW3 = !ICW1_VAL[1];
    localparam bit SEND_ICW4 = ICW1_VAL[0];
    // Without ICW4 the PIC defaults to normal EOI, so an EOI is still needed.
    localparam bit SEND_EOI  = !SEND_ICW4 || !ICW4_VAL[1];

    localparam int             CW       = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(STROBE_CYCLES - 1);

    state_t         state, state_next;
    step_t          step, step_next;
    logic [CW-1:0]  cnt;
    logic           cnt_last;
    logic           load;
    logic           load_a1;
    logic [7:0]     load_data;
    logic           init_last_hold;

    // Next programmed word after s, skipping ICW3/ICW4 when ICW1 says so.
    function automatic step_t step_after(input step_t s);
        case (s)
            STEP_ICW1: return STEP_ICW2;
            STEP_ICW2: return SEND_ICW3 ? STEP_ICW3 : (SEND_ICW4 ? STEP_ICW4 : STEP_OCW1);
            STEP_ICW3: return SEND_ICW4 ? STEP_ICW4 : STEP_OCW1;
            default:   return STEP_OCW1;
        endcase
    endfunction

    function automatic logic [7:0] step_byte(input step_t s);
        case (s)
            STEP_ICW1: return ICW1_VAL;
            STEP_ICW2: return ICW2_VAL;
            STEP_ICW3: return ICW3_VAL;
            STEP_ICW4: return ICW4_VAL;
            default:   return OCW1_VAL;
        endcase
    endfunction

    assign cnt_last       = (cnt == CNT_LAST);
    assign init_last_hold = (state == WR_HOLD) && !init_done && (step == STEP_OCW1);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) state <= INIT_WR;
        else       state <= state_next;
    end

    // Next-state logic, plus the byte/address to latch when a write starts.
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        step_next  = step;
        load       = 1'b0;
        load_a1    = 1'b0;
        load_data  = 8'h00;
        case (state)
            INIT_WR: begin
                state_next = WR_SETUP;
                step_next  = STEP_ICW1;
                load       = 1'b1;
                load_data  = ICW1_VAL;
            end
            IDLE: begin
                if (interrupt_to_cpu) begin
                    state_next = ACK1;
                end else if (cmd_valid) begin
                    state_next = cmd_read ? RD_SETUP : WR_SETUP;
                    load       = 1'b1;
                    load_a1    = cmd_a1;
                    load_data  = cmd_data;
                end
            end
            WR_SETUP:  state_next = WR_STROBE;
            WR_STROBE: if (cnt_last) state_next = WR_HOLD;
            WR_HOLD: begin
                // During init the next word follows with CS held low.
                if (!init_done && step != STEP_OCW1) begin
                    state_next = WR_SETUP;
                    step_next  = step_after(step);
                    load       = 1'b1;
                    load_a1    = 1'b1;
                    load_data  = step_byte(step_after(step));
                end else begin
                    state_next = IDLE;
                end
            end
            RD_SETUP:  state_next = RD_STROBE;
            RD_STROBE: if (cnt_last) state_next = RD_HOLD;
            RD_HOLD:   state_next = IDLE;
            ACK1:      if (cnt_last) state_next = ACK_GAP;
            ACK_GAP:   state_next = ACK2;
            ACK2:      if (cnt_last) state_next = ACK_DONE;
            ACK_DONE:  state_next = SEND_EOI ? EOI_WR : IDLE;
            EOI_WR: begin
                state_next = WR_SETUP;
                load       = 1'b1;
                load_data  = EOI_CMD;
            end
            default:   state_next = INIT_WR;
        endcase
    end

    // Datapath registers: strobe counter, bus byte, captures, init flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            step      <= STEP_ICW1;
            cnt       <= '0;
            A1        <= 1'b0;
            data_out  <= 8'h00;
            rsp_data  <= 8'h00;
            vector    <= 8'h00;
            init_done <= 1'b0;
        end else begin
            step <= step_next;
            // Counter restarts on every state change; it only matters in strobes.
            cnt  <= (state_next == state) ? cnt + 1'b1 : '0;
            if (load) begin
                A1       <= load_a1;
                data_out <= load_data;
            end
            if (state == RD_STROBE && cnt_last) rsp_data <= data_in;
            if (state == ACK2 && cnt_last)      vector   <= data_in;
            if (init_last_hold)                 init_done <= 1'b1;
        end
    end

    // Bus and handshake outputs decoded from state.
    always_comb begin
        CS           = 1'b1;
        wr_enable    = 1'b1;
        rd_enable    = 1'b1;
        int_ack      = 1'b1;
        data_oe      = 1'b0;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        vector_valid = 1'b0;
        case (state)
            WR_SETUP, WR_HOLD: begin
                CS      = 1'b0;
                data_oe = 1'b1;
            end
            WR_STROBE: begin
                CS        = 1'b0;
                data_oe   = 1'b1;
                wr_enable = 1'b0;
            end
            RD_SETUP:  CS = 1'b0;
            RD_STROBE: begin
                CS        = 1'b0;
                rd_enable = 1'b0;
            end
            RD_HOLD: begin
                CS        = 1'b0;
                rsp_valid = 1'b1;
            end
            ACK1, ACK2: int_ack      = 1'b0;
            ACK_DONE:   vector_valid = 1'b1;
            IDLE:       cmd_ready    = init_done && !interrupt_to_cpu;
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
